idct8_pipe: RTL

- Pipelined 8-point inverse integer DCT, the decode-side counterpart of the team's fastDCT8 forward transform.
- Uses the same coefficient set (64, 83, 36, 89, 75, 50, 18) in partial-butterfly form.
- Takes one block of 8 coefficients per accepted transfer and returns 8 reconstructed samples.
- Output is rounded, shifted and saturated, with valid/ready flow control on both sides.
- Sits after coefficient storage and before the sample writer in the 2D IDCT path; used twice, once for columns and once for rows.

---
 rtl/idct8_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/idct8_pipe.sv
// idct8_pipe: three-stage elastic 8-point inverse integer DCT.
// S1 registers the coefficient block, S2 forms the even/odd partial
// butterflies with shift-add constant multiplies, S3 recombines, rounds,
// shifts and saturates each lane. Output-side valid/ready backpressure
// ripples combinationally back to in_ready through the stage enables.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready; data is held stable while
// valid is high and ready is low.
module idct8_pipe #(
  parameter int CW    = 18,
  parameter int OW    = 9,
  parameter int SHIFT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0][CW-1:0]  coef,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0][OW-1:0]  x,
  output logic                out_sat
);

  // Internal butterfly width and recombination width (one guard bit).
  localparam int IW = CW + 11;
  localparam int RW = IW + 1;

  localparam logic signed [RW-1:0] RND  = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (OW - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  // Constant multiply as a sum of shifted copies; k is always a literal
  // at the call site so this reduces to a small adder tree.
  function automatic logic signed [IW-1:0] cmul(input logic signed [IW-1:0] a,
                                                input logic [6:0] k);
    logic signed [IW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 7; b++) begin
      if (k[b]) acc = acc + (a <<< b);
    end
    return acc;
  endfunction

  logic                s1_valid, s2_valid, s3_valid;
  logic                s1_en, s2_en, s3_en;
  logic [7:0][CW-1:0]  s1_coef;
  logic signed [IW-1:0] s2_e [4];
  logic signed [IW-1:0] s2_o [4];
  logic signed [IW-1:0] e_d  [4];
  logic signed [IW-1:0] o_d  [4];
  logic [7:0][OW-1:0]  x_d;
  logic                sat_d;
  logic [7:0][OW-1:0]  x_q;
  logic                sat_q;

  // A stage may load when empty or when its content moves on this cycle.
  assign s3_en     = !s3_valid || out_ready;
  assign s2_en     = !s2_valid || s3_en;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = !rst && s1_en;
  assign out_valid = s3_valid;
  assign x         = x_q;
  assign out_sat   = sat_q;

  // S1: capture the incoming coefficient block.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_coef <= coef;
    end
  end

  // S2 datapath: even part from c0/c2/c4/c6, odd part from c1/c3/c5/c7.
  always_comb begin
    logic signed [IW-1:0] ce [8];
    logic signed [IW-1:0] big_e0, big_e1, p0, p1;
    for (int i = 0; i < 8; i++) begin
      ce[i] = {{(IW-CW){s1_coef[i][CW-1]}}, s1_coef[i]};
    end
    big_e0 = cmul(ce[0] + ce[4], 7'd64);
    big_e1 = cmul(ce[0] - ce[4], 7'd64);
    p0     = cmul(ce[2], 7'd83) + cmul(ce[6], 7'd36);
    p1     = cmul(ce[2], 7'd36) - cmul(ce[6], 7'd83);
    e_d[0] = big_e0 + p0;
    e_d[3] = big_e0 - p0;
    e_d[1] = big_e1 + p1;
    e_d[2] = big_e1 - p1;
    o_d[0] = cmul(ce[1], 7'd89) + cmul(ce[3], 7'd75) + cmul(ce[5], 7'd50) + cmul(ce[7], 7'd18);
    o_d[1] = cmul(ce[1], 7'd75) - cmul(ce[3], 7'd18) - cmul(ce[5], 7'd89) - cmul(ce[7], 7'd50);
    o_d[2] = cmul(ce[1], 7'd50) - cmul(ce[3], 7'd89) + cmul(ce[5], 7'd18) + cmul(ce[7], 7'd75);
    o_d[3] = cmul(ce[1], 7'd18) - cmul(ce[3], 7'd50) + cmul(ce[5], 7'd75) - cmul(ce[7], 7'd89);
  end

  // S2: register the even/odd butterfly terms.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int k = 0; k < 4; k++) begin
          s2_e[k] <= e_d[k];
          s2_o[k] <= o_d[k];
        end
      end
    end
  end

  // S3 datapath: recombine, round half up, arithmetic shift, clip.
  always_comb begin
    logic signed [RW-1:0] r [8];
    logic signed [RW-1:0] y [8];
    logic signed [RW-1:0] ev, ov;
    x_d   = '0;
    sat_d = 1'b0;
    ev    = '0;
    ov    = '0;
    for (int n = 0; n < 8; n++) begin
      r[n] = '0;
      y[n] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      ev       = {s2_e[k][IW-1], s2_e[k]};
      ov       = {s2_o[k][IW-1], s2_o[k]};
      r[k]     = ev + ov;
      r[7-k]   = ev - ov;
    end
    for (int n = 0; n < 8; n++) begin
      y[n] = (r[n] + RND) >>> SHIFT;
      if (y[n] > MAXV) begin
        x_d[n] = MAXV[OW-1:0];
        sat_d  = 1'b1;
      end else if (y[n] < MINV) begin
        x_d[n] = MINV[OW-1:0];
        sat_d  = 1'b1;
      end else begin
        x_d[n] = y[n][OW-1:0];
      end
    end
  end

  // S3: output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      x_q      <= '0;
      sat_q    <= 1'b0;
    end else if (s3_en) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        x_q   <= x_d;
        sat_q <= sat_d;
      end
    end
  end

endmodule
